boa_extmem_sram_wide: RTL and testbench

Parametrised external SRAM controller, successor to the fixed 8-bit byte-serial controller. It bridges one 32-bit `boa_mem_bus` slave port to an asynchronous SRAM of 8, 16 or 32 bits data width, splitting each word access into 32/XW sequential beats. Each beat can be stretched by programmable wait states. It sits between the CPU memory mux and the board-level SRAM pins.

---
 rtl/boa_extmem_sram_wide_if.sv | 12 +
 rtl/boa_extmem_sram_wide.sv | 124 ++++++++++++
 tb/tb_boa_extmem_sram_wide.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/boa_extmem_sram_wide_if.sv
// boa_mem_bus: 32-bit CPU memory bus. The CPU side drives requests; the memory side returns rdata and ready.
interface boa_mem_bus;
  logic        re;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport MEM (input re, we, addr, wdata, output rdata, ready);
  modport CPU (output re, we, addr, wdata, input rdata, ready);
endinterface

// File: rtl/boa_extmem_sram_wide.sv
// boa_extmem_sram_wide: bridges a 32-bit boa_mem_bus to an 8/16/32-bit async SRAM using 32/XW beats.
// Define BOA_EXTMEM_SRAM_SKIP_EN to skip write beats that have no enabled byte lanes.
//   state | meaning
//   IDLE  | bus ready, SRAM strobes off, waiting for re or we
//   BEAT  | driving beat `beat` to the SRAM, held for wait_states+1 cycles
module boa_extmem_sram_wide #(
  parameter int sram_alen   = 16,
  parameter int xm_width    = 8,
  parameter int wait_states = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  boa_mem_bus.MEM               bus,
  output logic                  xm_re,
  output logic [xm_width/8-1:0] xm_we,
  output logic [sram_alen-1:0]  xm_addr,
  output logic [xm_width-1:0]   xm_wdata,
  input  logic [xm_width-1:0]   xm_rdata
);

  localparam int NB = 32 / xm_width;
  localparam int LN = xm_width / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BEAT = 1'b1;

  logic [0:0]           state;
  logic [BW-1:0]        beat;
  logic [3:0]           ws;
  logic [sram_alen-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic [3:0]           we_q;
  logic                 wr_q;

  logic                 accept;
  logic                 last_cyc;
  logic [BW-1:0]        start_beat;
  logic [BW-1:0]        next_beat;
  logic                 more_beats;

  assign accept   = (state == IDLE) && (bus.re || (|bus.we));
  assign last_cyc = (ws == 4'(wait_states));

`ifdef BOA_EXTMEM_SRAM_SKIP_EN
  // Returns {hit, index} of the lowest beat >= from whose write-enable slice is nonzero.
  function automatic logic [BW:0] find_lane(input logic [3:0] we, input int from);
    logic [BW:0] r;
    r = '0;
    for (int k = NB - 1; k >= 0; k--) begin
      if (k >= from && (|we[k*LN +: LN])) r = {1'b1, BW'(k)};
    end
    return r;
  endfunction

  logic [BW:0] first_sel;
  logic [BW:0] next_sel;

  assign first_sel  = find_lane(bus.we, 0);
  assign next_sel   = find_lane(we_q, int'(beat) + 1);
  assign start_beat = first_sel[BW] ? first_sel[BW-1:0] : '0;
  assign more_beats = wr_q ? next_sel[BW] : (int'(beat) != NB - 1);
  assign next_beat  = wr_q ? next_sel[BW-1:0] : BW'(int'(beat) + 1);
`else
  assign start_beat = '0;
  assign more_beats = (int'(beat) != NB - 1);
  assign next_beat  = BW'(int'(beat) + 1);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      beat    <= '0;
      ws      <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= '0;
      wr_q    <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        state   <= BEAT;
        addr_q  <= bus.addr[sram_alen-1:0] & ~sram_alen'(3);
        wdata_q <= bus.wdata;
        we_q    <= bus.we;
        wr_q    <= |bus.we;
        beat    <= start_beat;
        ws      <= '0;
      end
    end else begin
      if (last_cyc) begin
        ws <= '0;
        if (!wr_q) rdata_q[int'(beat)*xm_width +: xm_width] <= xm_rdata;
        if (more_beats) begin
          beat <= next_beat;
        end else begin
          state <= IDLE;
          beat  <= '0;
        end
      end else begin
        ws <= ws + 4'd1;
      end
    end
  end

  // SRAM strobes decode from registered state only, so bus inputs never reach the pins combinationally.
  always_comb begin
    xm_re    = 1'b0;
    xm_we    = '0;
    xm_addr  = '0;
    xm_wdata = '0;
    if (state == BEAT) begin
      xm_addr  = addr_q | sram_alen'(int'(beat) * LN);
      xm_wdata = wdata_q[int'(beat)*xm_width +: xm_width];
      xm_we    = wr_q ? we_q[int'(beat)*LN +: LN] : '0;
      xm_re    = !wr_q;
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_boa_extmem_sram_wide.sv
// Scoreboard bench: three controllers (XW=8/W=0, XW=16/W=1, XW=32/W=3) on one clock, per-cycle beat checks.
module tb_boa_extmem_sram_wide;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  boa_mem_bus bus_a ();
  boa_mem_bus bus_b ();
  boa_mem_bus bus_c ();

  logic        xa_re, xb_re, xc_re;
  logic [0:0]  xa_we;
  logic [1:0]  xb_we;
  logic [3:0]  xc_we;
  logic [15:0] xa_addr, xb_addr, xc_addr;
  logic [7:0]  xa_wdata, xa_rdata;
  logic [15:0] xb_wdata, xb_rdata;
  logic [31:0] xc_wdata, xc_rdata;

  boa_extmem_sram_wide #(.sram_alen(16), .xm_width(8), .wait_states(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .xm_re(xa_re), .xm_we(xa_we),
    .xm_addr(xa_addr), .xm_wdata(xa_wdata), .xm_rdata(xa_rdata));
  boa_extmem_sram_wide #(.sram_alen(16), .xm_width(16), .wait_states(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .xm_re(xb_re), .xm_we(xb_we),
    .xm_addr(xb_addr), .xm_wdata(xb_wdata), .xm_rdata(xb_rdata));
  boa_extmem_sram_wide #(.sram_alen(16), .xm_width(32), .wait_states(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c), .xm_re(xc_re), .xm_we(xc_we),
    .xm_addr(xc_addr), .xm_wdata(xc_wdata), .xm_rdata(xc_rdata));

  // Read-only SRAM image shared by all three controllers.
  logic [7:0] mem [256];
  assign xa_rdata = mem[xa_addr[7:0]];
  assign xb_rdata = {mem[8'(xb_addr[7:0] + 8'd1)], mem[xb_addr[7:0]]};
  assign xc_rdata = {mem[8'(xc_addr[7:0] + 8'd3)], mem[8'(xc_addr[7:0] + 8'd2)],
                     mem[8'(xc_addr[7:0] + 8'd1)], mem[xc_addr[7:0]]};

  logic [15:0] m_addr  [3];
  logic [31:0] m_wdata [3];
  logic [3:0]  m_we    [3];
  logic        m_re    [3];
  logic        m_ready [3];
  logic [31:0] m_rdata [3];

  assign m_addr[0] = xa_addr;  assign m_wdata[0] = 32'(xa_wdata); assign m_we[0] = 4'(xa_we);
  assign m_addr[1] = xb_addr;  assign m_wdata[1] = 32'(xb_wdata); assign m_we[1] = 4'(xb_we);
  assign m_addr[2] = xc_addr;  assign m_wdata[2] = xc_wdata;      assign m_we[2] = xc_we;
  assign m_re[0] = xa_re;      assign m_re[1] = xb_re;            assign m_re[2] = xc_re;
  assign m_ready[0] = bus_a.ready; assign m_ready[1] = bus_b.ready; assign m_ready[2] = bus_c.ready;
  assign m_rdata[0] = bus_a.rdata; assign m_rdata[1] = bus_b.rdata; assign m_rdata[2] = bus_c.rdata;

  int XWS [3] = '{8, 16, 32};
  int WSS [3] = '{0, 1, 3};

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
  } beat_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [15:0] cyc;
  } done_t;

  beat_t bq [3][$];
  done_t dq [3][$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected SRAM beats for one access, one record per cycle.
  task automatic push_access(input int i, input logic [3:0] we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata_exp);
    int    xw, w, n, ln, cyc;
    logic  wr;
    logic [3:0]  sl, lmask;
    logic [31:0] dmask;
    beat_t b;
    done_t d;
    xw = XWS[i]; w = WSS[i]; n = 32 / xw; ln = xw / 8; cyc = 0;
    wr = (we != 4'd0);
    lmask = 4'((1 << ln) - 1);
    dmask = 32'((64'd1 << xw) - 64'd1);
    for (int k = 0; k < n; k++) begin
      sl = (we >> (k * ln)) & lmask;
`ifdef BOA_EXTMEM_SRAM_SKIP_EN
      if (wr && sl == 4'd0) continue;
`endif
      for (int c = 0; c <= w; c++) begin
        b.addr  = (addr[15:0] & 16'hFFFC) | 16'(k * ln);
        b.wdata = (wdata >> (k * xw)) & dmask;
        b.we    = wr ? sl : 4'd0;
        b.re    = !wr;
        bq[i].push_back(b);
        cyc++;
      end
    end
    d.rdata = rdata_exp;
    d.cyc   = 16'(cyc);
    dq[i].push_back(d);
  endtask

  task automatic drive(input int i, input logic re, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    case (i)
      0: begin bus_a.re = re; bus_a.we = we; bus_a.addr = addr; bus_a.wdata = wdata; end
      1: begin bus_b.re = re; bus_b.we = we; bus_b.addr = addr; bus_b.wdata = wdata; end
      default: begin bus_c.re = re; bus_c.we = we; bus_c.addr = addr; bus_c.wdata = wdata; end
    endcase
  endtask

  // Holds the request until the controller shows ready, then clears it right after the accept edge.
  task automatic issue(input int i, input logic re, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata_exp);
    logic ok;
    ok = 1'b0;
    drive(i, re, we, addr, wdata);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (m_ready[i]) begin ok = 1'b1; break; end
    end
    if (!ok) check($sformatf("accept_timeout%0d", i), 64'd0, 64'd1);
    else push_access(i, we, addr, wdata, rdata_exp);
    @(posedge clk); #1;
    drive(i, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic check_reset_state(input int i);
    check($sformatf("rst_state%0d", i),
          {m_ready[i], m_rdata[i], m_addr[i], m_we[i], m_re[i]}, {1'b1, 32'd0, 16'd0, 4'd0, 1'b0});
    check($sformatf("rst_wdata%0d", i), m_wdata[i], 64'd0);
  endtask

  // Monitor: every BEAT cycle pops one expected beat; each rising ready pops one completion.
  int    cnt      [3];
  logic  prev_rdy [3];
  beat_t e_b;
  done_t e_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin cnt[i] = 0; prev_rdy[i] = 1'b1; end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!m_ready[i]) begin
          cnt[i]++;
          if (bq[i].size() == 0) begin
            check($sformatf("beat_underflow%0d", i), 64'd1, 64'd0);
          end else begin
            e_b = bq[i].pop_front();
            check($sformatf("beat%0d", i), {m_addr[i], m_wdata[i], m_we[i], m_re[i]}, e_b);
          end
        end else begin
          if (!prev_rdy[i]) begin
            if (dq[i].size() == 0) begin
              check($sformatf("done_underflow%0d", i), 64'd1, 64'd0);
            end else begin
              e_d = dq[i].pop_front();
              check($sformatf("rdata%0d", i), m_rdata[i], e_d.rdata);
              check($sformatf("latency%0d", i), cnt[i], e_d.cyc);
            end
            cnt[i] = 0;
          end
          check($sformatf("idle_strobes%0d", i), {m_we[i], m_re[i]}, 64'd0);
        end
        prev_rdy[i] = m_ready[i];
      end
    end
  end

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 8'hEE;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    mem[8'h50] = 8'h78; mem[8'h51] = 8'h56; mem[8'h52] = 8'h34; mem[8'h53] = 8'h12;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 4'd0, 32'd0, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_reset_state(i);
    rst_n = 1'b1;

    // 8-bit, W=0
    issue(0, 1'b1, 4'h0, 32'h0000_0010, 32'h0, 32'h4433_2211);
    issue(0, 1'b1, 4'h0, 32'hABCD_0050, 32'h0, 32'h1234_5678);
    issue(0, 1'b0, 4'h8, 32'h0000_0040, 32'hDEAD_BEEF, 32'h1234_5678);
    issue(0, 1'b1, 4'h3, 32'h0000_0060, 32'h0000_CAFE, 32'h1234_5678);

    // Reset during beat 1 of a read
    issue(0, 1'b1, 4'h0, 32'h0000_0010, 32'h0, 32'h4433_2211);
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin bq[i].delete(); dq[i].delete(); end
    @(posedge clk); #1;
    check("midrst_re", xa_re, 64'd0);
    check("midrst_we", xa_we, 64'd0);
    check("midrst_ready", bus_a.ready, 64'd1);
    check("midrst_rdata", bus_a.rdata, 64'd0);
    check("midrst_addr", xa_addr, 64'd0);
    rst_n = 1'b1;
    issue(0, 1'b1, 4'h0, 32'h0000_0010, 32'h0, 32'h4433_2211);

    // 16-bit, W=1
    issue(1, 1'b0, 4'hF, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0);
    issue(1, 1'b1, 4'h0, 32'h0000_0010, 32'h0, 32'h4433_2211);
    issue(1, 1'b0, 4'h4, 32'h0000_0020, 32'h00AB_0000, 32'h4433_2211);

    // 32-bit, W=3: back-to-back read then write, unaligned addresses
    issue(2, 1'b1, 4'h0, 32'h0000_0050, 32'h0, 32'h1234_5678);
    issue(2, 1'b0, 4'hF, 32'h0000_0013, 32'h55AA_55AA, 32'h1234_5678);
    issue(2, 1'b1, 4'h0, 32'hFFFF_0012, 32'h0, 32'h4433_2211);

    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (dq[0].size() == 0 && dq[1].size() == 0 && dq[2].size() == 0) break;
    end
    @(negedge clk);
    check("drain_done", dq[0].size() + dq[1].size() + dq[2].size(), 64'd0);
    check("drain_beats", bq[0].size() + bq[1].size() + bq[2].size(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
